// File: rtl/util_decode_sched_if.sv
// Decoder handshake bundle between util_decode_sched and a decode_fp unit.
//   master (scheduler): drives dec_start, dec_ack, dec_in; samples dec_done, dec_d1, dec_d2
//   slave  (decoder)  : the mirror image
interface util_decode_sched_if #(
    parameter int unsigned WORD_W = 16
);
    logic              dec_start;
    logic              dec_ack;
    logic [WORD_W-1:0] dec_in;
    logic              dec_done;
    logic [3:0]        dec_d1;
    logic [3:0]        dec_d2;

    modport master (
        output dec_start,
        output dec_ack,
        output dec_in,
        input  dec_done,
        input  dec_d1,
        input  dec_d2
    );

    modport slave (
        input  dec_start,
        input  dec_ack,
        input  dec_in,
        output dec_done,
        output dec_d1,
        output dec_d2
    );
endinterface

// File: rtl/util_decode_sched.sv
// util_decode_sched: walks the packed utility vector one cell at a time, pushes each word
// through a single decode_fp unit (Start/Ack/Done) and packs the two returned digits per cell
// into conv_1 / conv_2.
//
// Ports:
//   clk, Reset_n      clock (rising edge), asynchronous active-low reset
//   start, ack        begin a pass from idle / acknowledge a finished pass
//   cur_util, world   packed utilities (cell i at [i*WORD_W +: WORD_W]) and cell types
//   dec               decoder handshake (master modport of util_decode_sched_if)
//   conv_1, conv_2    decoded digits, cell i at [i*4 +: 4]
//   idx, busy, done   current cell, pass in progress, pass complete (held until ack)
//   err               sticky, a cell timed out during this pass
//
// Build option: define UTIL_WALL_SKIP_EN to skip wall cells (world code 2'b11); they are not
// sent to the decoder and get 4'hF in both digits.
module util_decode_sched #(
    parameter int unsigned NUM_CELLS = 12,
    parameter int unsigned WORD_W    = 16,
    parameter int unsigned TIMEOUT   = 255
) (
    input  logic                        clk,
    input  logic                        Reset_n,
    input  logic                        start,
    input  logic                        ack,
    input  logic [NUM_CELLS*WORD_W-1:0] cur_util,
    input  logic [2*NUM_CELLS-1:0]      world,
    util_decode_sched_if.master         dec,
    output logic [NUM_CELLS*4-1:0]      conv_1,
    output logic [NUM_CELLS*4-1:0]      conv_2,
    output logic [7:0]                  idx,
    output logic                        busy,
    output logic                        done,
    output logic                        err
);

    localparam int unsigned   CntW       = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CntW-1:0] TimeoutCnt = CntW'(TIMEOUT);
    localparam logic [7:0]    LastIdx    = 8'(NUM_CELLS - 1);

    typedef enum logic [2:0] {
        StIdle, StLoad, StReq, StWait, StRelease, StNext, StFinish
    } state_e;

    state_e                      state_q, state_d;
    logic [7:0]                  idx_q, idx_d;
    logic [CntW-1:0]             cnt_q, cnt_d;
    logic [NUM_CELLS*WORD_W-1:0] snap_util_q, snap_util_d;
    logic [NUM_CELLS*4-1:0]      conv_1_q, conv_1_d;
    logic [NUM_CELLS*4-1:0]      conv_2_q, conv_2_d;
    logic                        err_q, err_d;
    logic [WORD_W-1:0]           dec_in_q, dec_in_d;
    logic                        cur_wall;

    function automatic logic [WORD_W-1:0] word_at(input logic [NUM_CELLS*WORD_W-1:0] vec,
                                                  input logic [7:0] sel);
        logic [WORD_W-1:0] w;
        w = '0;
        for (int unsigned c = 0; c < NUM_CELLS; c++) begin
            if (sel == 8'(c)) w = vec[c*WORD_W +: WORD_W];
        end
        return w;
    endfunction

    function automatic logic [NUM_CELLS*4-1:0] put_digit(input logic [NUM_CELLS*4-1:0] vec,
                                                         input logic [7:0] sel,
                                                         input logic [3:0] val);
        logic [NUM_CELLS*4-1:0] v;
        v = vec;
        for (int unsigned c = 0; c < NUM_CELLS; c++) begin
            if (sel == 8'(c)) v[c*4 +: 4] = val;
        end
        return v;
    endfunction

`ifdef UTIL_WALL_SKIP_EN
    logic [2*NUM_CELLS-1:0] snap_world_q, snap_world_d;

    always_comb begin
        cur_wall = 1'b0;
        for (int unsigned c = 0; c < NUM_CELLS; c++) begin
            if (idx_q == 8'(c)) cur_wall = &snap_world_q[2*c +: 2];
        end
    end

    always_ff @(posedge clk or negedge Reset_n) begin
        if (!Reset_n) snap_world_q <= '0;
        else          snap_world_q <= snap_world_d;
    end
`else
    logic unused_world;
    assign unused_world = ^world;
    assign cur_wall     = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        cnt_d       = cnt_q;
        snap_util_d = snap_util_q;
        conv_1_d    = conv_1_q;
        conv_2_d    = conv_2_q;
        err_d       = err_q;
        dec_in_d    = dec_in_q;
`ifdef UTIL_WALL_SKIP_EN
        snap_world_d = snap_world_q;
`endif
        case (state_q)
            StIdle: begin
                if (start) state_d = StLoad;
            end
            StLoad: begin
                snap_util_d = cur_util;
`ifdef UTIL_WALL_SKIP_EN
                snap_world_d = world;
`endif
                idx_d       = '0;
                conv_1_d    = '0;
                conv_2_d    = '0;
                err_d       = 1'b0;
                // dec_in must already be valid while dec_start is high in the first REQ.
                dec_in_d    = cur_util[WORD_W-1:0];
                state_d     = StReq;
            end
            StReq: begin
                cnt_d = '0;
                if (cur_wall) begin
                    conv_1_d = put_digit(conv_1_q, idx_q, 4'hF);
                    conv_2_d = put_digit(conv_2_q, idx_q, 4'hF);
                    state_d  = StNext;
                end else begin
                    state_d  = StWait;
                end
            end
            StWait: begin
                if (dec.dec_done) begin
                    conv_1_d = put_digit(conv_1_q, idx_q, dec.dec_d1);
                    conv_2_d = put_digit(conv_2_q, idx_q, dec.dec_d2);
                    state_d  = StRelease;
                end else if (cnt_q == TimeoutCnt) begin
                    conv_1_d = put_digit(conv_1_q, idx_q, 4'hF);
                    conv_2_d = put_digit(conv_2_q, idx_q, 4'hF);
                    err_d    = 1'b1;
                    state_d  = StRelease;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StRelease: begin
                if (!dec.dec_done) state_d = StNext;
            end
            StNext: begin
                if (idx_q == LastIdx) begin
                    state_d = StFinish;
                end else begin
                    idx_d    = idx_q + 8'd1;
                    dec_in_d = word_at(snap_util_q, idx_q + 8'd1);
                    state_d  = StReq;
                end
            end
            StFinish: begin
                if (ack) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q     <= StIdle;
            idx_q       <= '0;
            cnt_q       <= '0;
            snap_util_q <= '0;
            conv_1_q    <= '0;
            conv_2_q    <= '0;
            err_q       <= 1'b0;
            dec_in_q    <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            cnt_q       <= cnt_d;
            snap_util_q <= snap_util_d;
            conv_1_q    <= conv_1_d;
            conv_2_q    <= conv_2_d;
            err_q       <= err_d;
            dec_in_q    <= dec_in_d;
        end
    end

    // Start and ack come from disjoint states, so they can never overlap.
    assign dec.dec_start = (state_q == StWait) || ((state_q == StReq) && !cur_wall);
    assign dec.dec_ack   = (state_q == StRelease);
    assign dec.dec_in    = dec_in_q;

    assign conv_1 = conv_1_q;
    assign conv_2 = conv_2_q;
    assign idx    = idx_q;
    assign err    = err_q;
    assign busy   = (state_q != StIdle) && (state_q != StFinish);
    assign done   = (state_q == StFinish);

endmodule

// File: tb/tb_util_decode_sched.sv
// Randomised scoreboard bench for util_decode_sched with a behavioural decode_fp model.
module tb_util_decode_sched;

    localparam int unsigned NumCells = 12;
    localparam int unsigned WordW    = 16;
    localparam int unsigned Timeout  = 255;
    localparam int          Bound    = 2000;

    localparam int ModeNone      = 0;
    localparam int ModeSnap      = 1;
    localparam int ModeBusyStart = 2;
    localparam int ModeStartAck  = 3;

    typedef struct packed {
        logic [NumCells*4-1:0] c1;
        logic [NumCells*4-1:0] c2;
        logic                  e;
    } exp_t;

    logic                       clk = 1'b0;
    logic                       Reset_n;
    logic                       start;
    logic                       ack;
    logic [NumCells*WordW-1:0]  cur_util;
    logic [2*NumCells-1:0]      world;
    logic [NumCells*4-1:0]      conv_1;
    logic [NumCells*4-1:0]      conv_2;
    logic [7:0]                 idx;
    logic                       busy;
    logic                       done;
    logic                       err;

    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t exp_q[$];
    exp_t last_exp;
    int   hang_idx = -1;
`ifdef UTIL_WALL_SKIP_EN
    logic [2*NumCells-1:0] world_snap;
`endif

    util_decode_sched_if #(.WORD_W(WordW)) dec_if ();

    util_decode_sched #(
        .NUM_CELLS (NumCells),
        .WORD_W    (WordW),
        .TIMEOUT   (Timeout)
    ) u_dut (
        .clk      (clk),
        .Reset_n  (Reset_n),
        .start    (start),
        .ack      (ack),
        .cur_util (cur_util),
        .world    (world),
        .dec      (dec_if),
        .conv_1   (conv_1),
        .conv_2   (conv_2),
        .idx      (idx),
        .busy     (busy),
        .done     (done),
        .err      (err)
    );

    always #5 clk = ~clk;

    // decode_fp model: accepts a start, answers after 1..3 cycles with the low byte's nibbles,
    // holds done until ack. The cell named by hang_idx never gets an answer.
    logic       dm_done, dm_pending;
    int         dm_cnt;
    logic [7:0] dm_byte;
    logic [3:0] dm_d1, dm_d2;

    assign dec_if.dec_done = dm_done;
    assign dec_if.dec_d1   = dm_d1;
    assign dec_if.dec_d2   = dm_d2;

    always @(posedge clk or negedge Reset_n) begin
        if (!Reset_n) begin
            dm_done    <= 1'b0;
            dm_pending <= 1'b0;
            dm_cnt     <= 0;
            dm_byte    <= '0;
            dm_d1      <= '0;
            dm_d2      <= '0;
        end else if (dm_done) begin
            if (dec_if.dec_ack) dm_done <= 1'b0;
        end else if (dm_pending) begin
            if (dm_cnt <= 1) begin
                dm_pending <= 1'b0;
                dm_done    <= 1'b1;
                dm_d1      <= dm_byte[7:4];
                dm_d2      <= dm_byte[3:0];
            end else begin
                dm_cnt <= dm_cnt - 1;
            end
        end else if (dec_if.dec_start && int'(idx) != hang_idx) begin
            dm_pending <= 1'b1;
            dm_cnt     <= int'($urandom_range(1, 3));
            dm_byte    <= dec_if.dec_in[7:0];
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Expected result of one pass, straight from the cell rules.
    function automatic exp_t model(input logic [NumCells*WordW-1:0] u, input int hang);
        exp_t             r;
        logic [WordW-1:0] word;
        r = '0;
        for (int i = 0; i < int'(NumCells); i++) begin
            word = u[i*WordW +: WordW];
`ifdef UTIL_WALL_SKIP_EN
            if (world_snap[i*2 +: 2] == 2'b11) begin
                r.c1[i*4 +: 4] = 4'hF;
                r.c2[i*4 +: 4] = 4'hF;
                continue;
            end
`endif
            if (i == hang) begin
                r.c1[i*4 +: 4] = 4'hF;
                r.c2[i*4 +: 4] = 4'hF;
                r.e            = 1'b1;
            end else begin
                r.c1[i*4 +: 4] = 4'((word >> 4) % 16);
                r.c2[i*4 +: 4] = 4'(word % 16);
            end
        end
        return r;
    endfunction

    // Monitor: handshake invariants every cycle, scoreboard pop on each rising done.
    logic             done_prev  = 1'b0;
    logic             start_prev = 1'b0;
    logic [WordW-1:0] in_prev    = '0;

    always @(negedge clk) begin
        exp_t e;
        if (Reset_n) begin
            check("start_ack_exclusive", 64'(dec_if.dec_start & dec_if.dec_ack), 64'd0);
            if (start_prev && dec_if.dec_start)
                check("dec_in_stable", 64'(dec_if.dec_in), 64'(in_prev));
`ifdef UTIL_WALL_SKIP_EN
            if (dec_if.dec_start && idx < 8'(NumCells))
                check("wall_no_start", 64'(world_snap[int'(idx)*2 +: 2] == 2'b11), 64'd0);
`endif
            if (done && !done_prev) begin
                if (exp_q.size() == 0) begin
                    check("sb_unexpected_done", 64'd1, 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("sb_conv_1", 64'(conv_1), 64'(e.c1));
                    check("sb_conv_2", 64'(conv_2), 64'(e.c2));
                    check("sb_err", 64'(err), 64'(e.e));
                end
            end
        end
        done_prev  = Reset_n && done;
        start_prev = Reset_n && dec_if.dec_start;
        in_prev    = dec_if.dec_in;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_for_idx(input logic [7:0] target);
        int k = 0;
        while (!(busy && idx == target) && k < Bound) begin
            tick();
            k++;
        end
        check("reach_idx", 64'(busy && idx == target), 64'd1);
    endtask

    function automatic logic [NumCells*WordW-1:0] rand_util();
        logic [NumCells*WordW-1:0] u;
        for (int i = 0; i < int'(NumCells); i++) u[i*WordW +: WordW] = WordW'($urandom);
        return u;
    endfunction

    function automatic logic [2*NumCells-1:0] rand_world();
        logic [2*NumCells-1:0] w;
        for (int i = 0; i < int'(NumCells); i++) w[i*2 +: 2] = 2'($urandom);
        return w;
    endfunction

    task automatic run_pass(input logic [NumCells*WordW-1:0] u, input logic [2*NumCells-1:0] w,
                            input int hang, input int mode);
        int   k;
        logic bad;
        cur_util = u;
        world    = w;
        hang_idx = hang;
`ifdef UTIL_WALL_SKIP_EN
        world_snap = w;
`endif
        last_exp = model(u, hang);
        exp_q.push_back(last_exp);
        start = 1'b1;
        tick();
        start = 1'b0;
        if (mode == ModeSnap) begin
            wait_for_idx(8'd2);
            cur_util = rand_util();
            world    = rand_world();
        end
        if (mode == ModeBusyStart) begin
            wait_for_idx(8'd4);
            start = 1'b1;
            tick();
            start = 1'b0;
        end
        k   = 0;
        bad = 1'b0;
        while (!done && k < Bound) begin
            if (mode == ModeBusyStart && busy && idx < 8'd4) bad = 1'b1;
            tick();
            k++;
        end
        check("done_reached", 64'(done), 64'd1);
        if (mode == ModeBusyStart) check("no_restart_when_busy", 64'(bad), 64'd0);
        if (mode == ModeStartAck) begin
            start = 1'b1;
            ack   = 1'b1;
            tick();
            start = 1'b0;
            ack   = 1'b0;
            bad   = 1'b0;
            for (int i = 0; i < 4; i++) begin
                if (busy || done) bad = 1'b1;
                tick();
            end
            check("start_ack_stays_idle", 64'(bad), 64'd0);
        end else begin
            ack = 1'b1;
            tick();
            ack = 1'b0;
            check("ack_clears_done", 64'(done), 64'd0);
        end
        check("retain_conv_1", 64'(conv_1), 64'(last_exp.c1));
        check("retain_conv_2", 64'(conv_2), 64'(last_exp.c2));
    endtask

    initial begin
        logic [NumCells*WordW-1:0] u;
        logic [2*NumCells-1:0]     w;

        Reset_n  = 1'b0;
        start    = 1'b0;
        ack      = 1'b0;
        cur_util = '0;
        world    = '0;
        repeat (3) tick();
        check("rst_conv_1", 64'(conv_1), 64'd0);
        check("rst_conv_2", 64'(conv_2), 64'd0);
        check("rst_idx", 64'(idx), 64'd0);
        check("rst_busy_done_err", 64'({busy, done, err}), 64'd0);
        check("rst_dec_start_ack", 64'({dec_if.dec_start, dec_if.dec_ack}), 64'd0);
        check("rst_dec_in", 64'(dec_if.dec_in), 64'd0);
        Reset_n = 1'b1;
        tick();

        // Directed values; cell 5 marked as wall (only matters with wall skipping built in).
        u            = '0;
        u[15:0]      = 16'h3A66;
        u[31:16]     = 16'h2E61;
        w            = '0;
        w[11:10]     = 2'b11;
        run_pass(u, w, -1, ModeNone);
        check("basic_conv_1_lo", 64'(conv_1[7:0]), 64'h66);
        check("basic_conv_2_lo", 64'(conv_2[7:0]), 64'h16);
        check("basic_err", 64'(err), 64'd0);
`ifdef UTIL_WALL_SKIP_EN
        check("wall_conv_1_cell5", 64'(conv_1[23:20]), 64'hF);
`endif

        // Decoder never answers cell 5.
        run_pass(rand_util(), '0, 5, ModeNone);
        check("timeout_conv_1", 64'(conv_1[23:20]), 64'hF);
        check("timeout_conv_2", 64'(conv_2[23:20]), 64'hF);
        check("timeout_err", 64'(err), 64'd1);

        run_pass(rand_util(), rand_world(), -1, ModeSnap);
        run_pass(rand_util(), rand_world(), -1, ModeBusyStart);
        run_pass(rand_util(), rand_world(), -1, ModeStartAck);

        for (int p = 0; p < 6; p++) begin
            run_pass(rand_util(), rand_world(),
                     ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, NumCells - 1)) : -1,
                     ModeNone);
        end

        // Abort a pass with reset while cell 3 is waiting on the decoder.
        cur_util = rand_util();
        hang_idx = -1;
        start    = 1'b1;
        tick();
        start = 1'b0;
        wait_for_idx(8'd3);
        tick();
        check("mid_pass_in_wait", 64'(dec_if.dec_start && busy), 64'd1);
        #2;
        Reset_n = 1'b0;
        #1;
        check("abort_conv", 64'({conv_1, conv_2}), 64'd0);
        check("abort_idx", 64'(idx), 64'd0);
        check("abort_flags", 64'({busy, done, err}), 64'd0);
        check("abort_dec", 64'({dec_if.dec_start, dec_if.dec_ack, dec_if.dec_in}), 64'd0);
        tick();
        Reset_n = 1'b1;
        repeat (3) tick();
        check("abort_stays_idle", 64'({busy, done}), 64'd0);

        run_pass(rand_util(), rand_world(), -1, ModeNone);

        check("sb_drained", 64'(exp_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/util_decode_sched.md
Name: util_decode_sched

Overview:
- Sequencer that walks the packed utility vector produced by the MDP engine, cell by cell.
- Feeds each 16-bit fixed-point word through a single decode_fp unit using its Start/Ack/Done handshake.
- Packs the two returned 4-bit digits per cell into two display buffers.
- Sits between MD_state_machine (cur_util, world) and the display/top-level, replacing ad-hoc unpack sequencing.

Parameters:
- NUM_CELLS, 12, number of grid cells to decode (width*depth).
- WORD_W, 16, bits per utility word.
- TIMEOUT, 255, max cycles to wait for dec_done before abandoning a cell.

Ports:
- clk  input  1  system clock, rising edge.
- Reset_n  input  1  asynchronous, active-low reset.
- start  input  1  level/pulse; begins a decode pass when IDLE.
- ack  input  1  consumer acknowledge; clears done and returns to IDLE.
- cur_util  input  NUM_CELLS*WORD_W  packed utilities; cell i at [i*WORD_W +: WORD_W].
- world  input  2*NUM_CELLS  cell types; 2'b11 = wall.
- dec_start  output  1  Start to decode_fp.
- dec_ack  output  1  Ack to decode_fp.
- dec_in  output  WORD_W  Fp_in to decode_fp.
- dec_done  input  1  Done from decode_fp.
- dec_d1, dec_d2  input  4 each  Decode_1/Decode_2 from decode_fp.
- conv_1, conv_2  output  NUM_CELLS*4  decoded digit buffers; cell i at [i*4 +: 4].
- idx  output  8  cell currently being processed.
- busy  output  1  high in every state except IDLE and FINISH.
- done  output  1  pass complete; held until ack.
- err  output  1  sticky; a cell timed out during this pass.

Behaviour:
- Reset (Reset_n low, asynchronous):
  - State = IDLE.
  - All outputs 0, including conv_1/conv_2, dec_start, dec_ack and dec_in; internal snapshot cleared.
  - Reset mid-pass aborts immediately; no partial state survives.
- States:
  - IDLE: if start, go to LOAD. Otherwise hold; buffers retain the previous pass.
  - LOAD (1 cycle): snapshot cur_util and world into internal registers; idx=0; clear conv_1, conv_2, err; go to REQ.
  - REQ: dec_in = snapshot word[idx]; dec_start=1; wait counter=0; go to WAIT.
  - WAIT: hold dec_start and dec_in stable.
    - If dec_done: write conv_1[idx]=dec_d1 and conv_2[idx]=dec_d2; dec_start=0; go to RELEASE.
    - Else if wait counter == TIMEOUT: write 4'hF to both digits; set err; dec_start=0; go to RELEASE.
    - Else increment wait counter.
  - RELEASE: dec_ack=1; stay until dec_done==0.
    - Then dec_ack=0 and go to NEXT.
    - A timed-out decoder that never asserts done also passes straight through.
  - NEXT (1 cycle): if idx==NUM_CELLS-1, go to FINISH; else idx+1 and go to REQ.
  - FINISH: done=1. On ack, done=0 and go to IDLE.
- Simultaneous events:
  - start is ignored outside IDLE.
  - start and ack together in FINISH: ack wins and the block returns to IDLE; a new start is needed the cycle after.
- Inputs after LOAD:
  - cur_util and world changes are ignored; only the snapshot is used.
- Handshake rules:
  - dec_start and dec_ack are never high in the same cycle.
  - dec_in changes only in REQ.
- Latency:
  - Minimum per cell with a zero-wait decoder (done in the cycle after start): REQ + WAIT + RELEASE + NEXT = 4 cycles.
  - Whole pass: 1 + 4*NUM_CELLS cycles to FINISH.

Optional Feature:
- Macro: UTIL_WALL_SKIP_EN.
- Defined: in REQ, a cell whose snapshot world code is 2'b11 is not sent to the decoder. Both digits are written 4'hF and the state goes directly to NEXT, with no dec_start for that cell (2 cycles per wall cell).
- Undefined: the world input is ignored and every cell is decoded.

Test Plan:
- Reset mid-pass: start, then drop Reset_n during WAIT of cell 3 → all outputs 0 asynchronously, state IDLE, dec_start=0.
- Basic pass:
  - Decoder model: done 2 cycles after start, d1=in[7:4], d2=in[3:0].
  - cell0=16'h3A66, cell1=16'h2E61, others 16'h0000.
  - Result: conv_1[7:0]=8'h66, conv_2[7:0]=8'h16, done after ack handshakes for all 12 cells, err=0.
- Timeout: model never asserts done for cell 5 → after TIMEOUT cycles conv_1[23:20]=4'hF and conv_2[23:20]=4'hF, err=1, pass continues to done.
- Handshake/snapshot:
  - Change cur_util during cell 2 → buffers reflect the LOAD-time values.
  - Checker asserts dec_start and dec_ack are never simultaneously high.
  - Checker asserts dec_in is stable while dec_start=1.
- Done/ack interaction: hold start and ack high together in FINISH → returns to IDLE, no new pass until start re-asserted; start asserted while busy → no effect.
- UTIL_WALL_SKIP_EN defined:
  - world cell5=2'b11.
  - No dec_start while idx==5; conv_1[23:20]=4'hF.
  - Total pass 2 cycles shorter than without the macro.
